// File: rtl/iq_select_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | Module      : iq_select_scheduler_if                                       |
// | Description : CIQ <-> select/schedule stage bundle (requests, grants, wake)|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface iq_select_scheduler_if #(
    parameter int ENTRIES    = 16,
    parameter int ADDR_W     = 4,
    parameter int AGE_WIDTH  = 5,
    parameter int PRF_WIDTH  = 6,
    parameter int LS_CREDITS = 4
);
    localparam int c_cr_w = $clog2(LS_CREDITS + 1);

    logic                           flush;
    logic [ENTRIES-1:0]             req_alu;
    logic [ENTRIES-1:0]             req_mul;
    logic [ENTRIES-1:0]             req_ls;
    logic [ENTRIES*AGE_WIDTH-1:0]   age_flat;
    logic [ENTRIES*PRF_WIDTH-1:0]   prd_flat;
    logic [ENTRIES-1:0]             prd_v;
    logic                           ls_done;

    logic                           grant_alu0;
    logic                           grant_alu1;
    logic                           grant_mul;
    logic                           grant_ls;
    logic [ADDR_W-1:0]              addr_alu0;
    logic [ADDR_W-1:0]              addr_alu1;
    logic [ADDR_W-1:0]              addr_mul;
    logic [ADDR_W-1:0]              addr_ls;
    logic                           mul_busy;
    logic                           wake_mul_v;
    logic [PRF_WIDTH-1:0]           wake_mul_prd;
    logic [c_cr_w-1:0]              ls_credit;

    modport master (
        output flush, req_alu, req_mul, req_ls, age_flat, prd_flat, prd_v, ls_done,
        input  grant_alu0, grant_alu1, grant_mul, grant_ls,
        input  addr_alu0, addr_alu1, addr_mul, addr_ls,
        input  mul_busy, wake_mul_v, wake_mul_prd, ls_credit
    );

    modport slave (
        input  flush, req_alu, req_mul, req_ls, age_flat, prd_flat, prd_v, ls_done,
        output grant_alu0, grant_alu1, grant_mul, grant_ls,
        output addr_alu0, addr_alu1, addr_mul, addr_ls,
        output mul_busy, wake_mul_v, wake_mul_prd, ls_credit
    );
endinterface

`default_nettype wire

// File: rtl/iq_select_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module      : iq_select_scheduler                                          |
// | Description : Oldest-first select for ALU0/ALU1/MUL/LS, MUL busy + wakeup, |
// |               LSU credit tracking                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module iq_select_scheduler #(
    parameter int ENTRIES    = 16,
    parameter int ADDR_W     = 4,
    parameter int AGE_WIDTH  = 5,
    parameter int PRF_WIDTH  = 6,
    parameter int MUL_LAT    = 3,
    parameter int LS_CREDITS = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    iq_select_scheduler_if.slave bus
);
    localparam int c_cnt_w = $clog2(MUL_LAT);
    localparam int c_cr_w  = $clog2(LS_CREDITS + 1);
    localparam logic [c_cr_w-1:0]  c_ls_max = c_cr_w'(LS_CREDITS);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] idx;
    } pick_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Strict '<' keeps the first (lowest-index) entry on equal ages.
    function automatic pick_t pick_oldest(input logic [ENTRIES-1:0]           req,
                                          input logic [ENTRIES*AGE_WIDTH-1:0] ages);
        logic [AGE_WIDTH-1:0] best_age;
        pick_oldest = '0;
        best_age    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (req[i] && (!pick_oldest.v || (ages[i*AGE_WIDTH +: AGE_WIDTH] < best_age))) begin
                pick_oldest.v   = 1'b1;
                pick_oldest.idx = ADDR_W'(i);
                best_age        = ages[i*AGE_WIDTH +: AGE_WIDTH];
            end
        end
    endfunction

    pick_t              w_pick_alu0, w_pick_alu1, w_pick_mul, w_pick_ls;
    logic [ENTRIES-1:0] w_alu1_req;
    logic               w_block;
    logic               w_gnt_alu0, w_gnt_alu1, w_gnt_mul, w_gnt_ls;

    state_e               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [PRF_WIDTH-1:0] mprd_q, mprd_d;
    logic                 mprdv_q, mprdv_d;
    logic                 wake_v_q, wake_v_d;
    logic [PRF_WIDTH-1:0] wake_prd_q, wake_prd_d;
    logic [c_cr_w-1:0]    credit_q, credit_d;

    always_comb begin
        w_block     = rst | bus.flush;
        w_pick_alu0 = pick_oldest(bus.req_alu, bus.age_flat);
        w_alu1_req  = bus.req_alu;
        if (w_pick_alu0.v) begin
            w_alu1_req[w_pick_alu0.idx] = 1'b0;
        end
        w_pick_alu1 = pick_oldest(w_alu1_req, bus.age_flat);
        w_pick_mul  = pick_oldest(bus.req_mul, bus.age_flat);
        w_pick_ls   = pick_oldest(bus.req_ls, bus.age_flat);

        w_gnt_alu0 = w_pick_alu0.v & ~w_block;
        w_gnt_alu1 = w_pick_alu1.v & ~w_block;
        w_gnt_mul  = w_pick_mul.v & (state_q == S_IDLE) & ~w_block;
        // Credit check uses the registered count, so a same-cycle ls_done cannot unblock.
        w_gnt_ls   = w_pick_ls.v & (credit_q != '0) & ~w_block;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mprd_d  = mprd_q;
        mprdv_d = mprdv_q;
        case (state_q)
            S_IDLE: begin
                if (w_gnt_mul) begin
                    state_d = S_BUSY;
                    cnt_d   = c_cnt_w'(MUL_LAT - 1);
                    mprd_d  = bus.prd_flat[w_pick_mul.idx*PRF_WIDTH +: PRF_WIDTH];
                    mprdv_d = bus.prd_v[w_pick_mul.idx];
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - c_cnt_one;
                if (cnt_q == c_cnt_one) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
        // Wake is registered: raise it for the last busy cycle (count 1).
        wake_v_d   = (state_d == S_BUSY) && (cnt_d == c_cnt_one) && mprdv_d;
        wake_prd_d = wake_v_d ? mprd_d : '0;
    end

    always_comb begin
        credit_d = credit_q;
        if (bus.flush) begin
            credit_d = c_ls_max;
        end else if (w_gnt_ls && !bus.ls_done) begin
            credit_d = credit_q - c_cr_w'(1);
        end else if (!w_gnt_ls && bus.ls_done && (credit_q != c_ls_max)) begin
            credit_d = credit_q + c_cr_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mprd_q     <= '0;
            mprdv_q    <= 1'b0;
            wake_v_q   <= 1'b0;
            wake_prd_q <= '0;
            credit_q   <= c_ls_max;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mprd_q     <= mprd_d;
            mprdv_q    <= mprdv_d;
            wake_v_q   <= wake_v_d;
            wake_prd_q <= wake_prd_d;
            credit_q   <= credit_d;
        end
    end

    assign bus.grant_alu0   = w_gnt_alu0;
    assign bus.grant_alu1   = w_gnt_alu1;
    assign bus.grant_mul    = w_gnt_mul;
    assign bus.grant_ls     = w_gnt_ls;
    assign bus.addr_alu0    = w_gnt_alu0 ? w_pick_alu0.idx : '0;
    assign bus.addr_alu1    = w_gnt_alu1 ? w_pick_alu1.idx : '0;
    assign bus.addr_mul     = w_gnt_mul  ? w_pick_mul.idx  : '0;
    assign bus.addr_ls      = w_gnt_ls   ? w_pick_ls.idx   : '0;
    assign bus.mul_busy     = (state_q == S_BUSY);
    assign bus.wake_mul_v   = wake_v_q;
    assign bus.wake_mul_prd = wake_prd_q;
    assign bus.ls_credit    = credit_q;

endmodule

`default_nettype wire

// File: tb/tb_iq_select_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_iq_select_scheduler                                       |
// | Description : Scenario bench for iq_select_scheduler with expected queue   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_iq_select_scheduler;
    localparam int ENTRIES    = 16;
    localparam int ADDR_W     = 4;
    localparam int AGE_WIDTH  = 5;
    localparam int PRF_WIDTH  = 6;
    localparam int MUL_LAT    = 3;
    localparam int LS_CREDITS = 4;

    typedef struct packed {
        logic       g0;
        logic [3:0] a0;
        logic       g1;
        logic [3:0] a1;
        logic       gm;
        logic [3:0] am;
        logic       gl;
        logic [3:0] al;
        logic       busy;
        logic       wv;
        logic [5:0] wp;
        logic [2:0] cred;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    iq_select_scheduler_if #(
        .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .AGE_WIDTH(AGE_WIDTH),
        .PRF_WIDTH(PRF_WIDTH), .LS_CREDITS(LS_CREDITS)
    ) bus ();

    iq_select_scheduler #(
        .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .AGE_WIDTH(AGE_WIDTH),
        .PRF_WIDTH(PRF_WIDTH), .MUL_LAT(MUL_LAT), .LS_CREDITS(LS_CREDITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic exp_t obs();
        return {bus.grant_alu0, bus.addr_alu0, bus.grant_alu1, bus.addr_alu1,
                bus.grant_mul, bus.addr_mul, bus.grant_ls, bus.addr_ls,
                bus.mul_busy, bus.wake_mul_v, bus.wake_mul_prd, bus.ls_credit};
    endfunction

    function automatic exp_t idle(input logic [2:0] cred);
        exp_t e;
        e      = '0;
        e.cred = cred;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush    = 1'b0;
        bus.req_alu  = '0;
        bus.req_mul  = '0;
        bus.req_ls   = '0;
        bus.age_flat = '1;
        bus.prd_flat = '0;
        bus.prd_v    = '0;
        bus.ls_done  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ls_done must never arrive while all credits are already home.
    always @(negedge clk) begin
        if (!rst && !bus.flush && bus.ls_done) begin
            n_checks++;
            if (bus.ls_credit == 3'(LS_CREDITS)) begin
                n_fail++;
                $display("FAIL ls_done_at_full: credit %0d, required below %0d", bus.ls_credit, LS_CREDITS);
            end
        end
    end

    task automatic test_reset();
        exp_t e;
        clear_inputs();
        rst         = 1'b1;
        bus.req_alu = '1;
        bus.req_mul = '1;
        bus.req_ls  = '1;
        tick();
        tick();
        sb.push_back(idle(3'd4));
        #3;
        e = sb.pop_front();
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_held: got %h required %h", obs(), e);
        end
        tick();
        rst = 1'b0;
        clear_inputs();
        sb.push_back(idle(3'd4));
        #3;
        e = sb.pop_front();
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_release: got %h required %h", obs(), e);
        end
        tick();
    endtask

    task automatic test_alu_select();
        exp_t e, x;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            x = idle(3'd4);
            bus.age_flat = '1;
            case (k)
                0: begin
                    bus.req_alu = 16'h0014;
                    bus.age_flat[2*AGE_WIDTH +: AGE_WIDTH] = 5'd7;
                    bus.age_flat[4*AGE_WIDTH +: AGE_WIDTH] = 5'd3;
                    x.g0 = 1'b1; x.a0 = 4'd4; x.g1 = 1'b1; x.a1 = 4'd2;
                end
                1: begin
                    bus.req_alu = 16'h0003;
                    bus.age_flat[0*AGE_WIDTH +: AGE_WIDTH] = 5'd5;
                    bus.age_flat[1*AGE_WIDTH +: AGE_WIDTH] = 5'd5;
                    x.g0 = 1'b1; x.a0 = 4'd0; x.g1 = 1'b1; x.a1 = 4'd1;
                end
                2: begin
                    bus.req_alu = 16'h0000;
                end
                3: begin
                    bus.req_alu = 16'h0100;
                    x.g0 = 1'b1; x.a0 = 4'd8;
                end
                4: begin
                    bus.req_alu = 16'h8001;
                    bus.age_flat[15*AGE_WIDTH +: AGE_WIDTH] = 5'd0;
                    bus.age_flat[0*AGE_WIDTH +: AGE_WIDTH]  = 5'd9;
                    x.g0 = 1'b1; x.a0 = 4'd15; x.g1 = 1'b1; x.a1 = 4'd0;
                end
                default: begin
                    bus.req_alu = 16'hFFFF;
                    for (int i = 0; i < ENTRIES; i++) begin
                        bus.age_flat[i*AGE_WIDTH +: AGE_WIDTH] = 5'(31 - i);
                    end
                    x.g0 = 1'b1; x.a0 = 4'd15; x.g1 = 1'b1; x.a1 = 4'd14;
                end
            endcase
            sb.push_back(x);
            #3;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL alu_case%0d: got %h required %h", k, obs(), e);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_mul_fsm();
        exp_t e, x;
        do_reset();
        bus.prd_flat[6*PRF_WIDTH +: PRF_WIDTH] = 6'h2A;
        bus.prd_v[6] = 1'b1;
        bus.req_mul  = 16'h0040;
        for (int k = 0; k < 7; k++) begin
            x = idle(3'd4);
            if (k == 3) bus.prd_v[6] = 1'b0;
            if (k == 4) bus.req_mul = '0;
            case (k)
                0, 3:    begin x.gm = 1'b1; x.am = 4'd6; end
                1, 4, 5: x.busy = 1'b1;
                2:       begin x.busy = 1'b1; x.wv = 1'b1; x.wp = 6'h2A; end
                default: ;
            endcase
            sb.push_back(x);
            #3;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL mul_cycle%0d: got %h required %h", k, obs(), e);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_ls_credits();
        exp_t e, x;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            x = idle(3'd0);
            bus.ls_done = 1'b0;
            bus.req_ls  = '0;
            case (k)
                0, 1, 2, 3: begin
                    bus.req_ls = 16'(1 << (8 + k));
                    x.gl = 1'b1; x.al = 4'(8 + k); x.cred = 3'(4 - k);
                end
                4:  bus.req_ls = 16'h1000;
                5:  begin bus.req_ls = 16'h1000; bus.ls_done = 1'b1; end
                6:  begin bus.req_ls = 16'h1000; x.gl = 1'b1; x.al = 4'd12; x.cred = 3'd1; end
                7:  ;
                8:  bus.ls_done = 1'b1;
                9:  begin bus.req_ls = 16'h0008; bus.ls_done = 1'b1; x.gl = 1'b1; x.al = 4'd3; x.cred = 3'd1; end
                default: x.cred = 3'd1;
            endcase
            sb.push_back(x);
            #3;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL ls_cycle%0d: got %h required %h", k, obs(), e);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        exp_t e, x;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            x = idle(3'd4);
            clear_inputs();
            case (k)
                0, 1: begin
                    bus.req_ls = 16'(1 << (8 + k));
                    x.gl = 1'b1; x.al = 4'(8 + k); x.cred = 3'(4 - k);
                end
                2: begin
                    bus.req_ls  = 16'h0400;
                    bus.req_mul = 16'h0040;
                    bus.prd_flat[6*PRF_WIDTH +: PRF_WIDTH] = 6'h15;
                    bus.prd_v[6] = 1'b1;
                    x.gl = 1'b1; x.al = 4'd10; x.cred = 3'd2; x.gm = 1'b1; x.am = 4'd6;
                end
                3: begin
                    bus.flush   = 1'b1;
                    bus.req_alu = '1;
                    bus.req_mul = '1;
                    bus.req_ls  = '1;
                    bus.ls_done = 1'b1;
                    x.busy = 1'b1; x.cred = 3'd1;
                end
                default: ;
            endcase
            sb.push_back(x);
            #3;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL flush_cycle%0d: got %h required %h", k, obs(), e);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_rst_mid_mul();
        exp_t e, x;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            x = idle(3'd4);
            clear_inputs();
            for (int i = 0; i < ENTRIES; i++) begin
                bus.age_flat[i*AGE_WIDTH +: AGE_WIDTH] = 5'd10;
            end
            bus.prd_v = '1;
            bus.prd_flat[0 +: PRF_WIDTH] = 6'h3F;
            if (k < 3) begin
                bus.req_alu = '1;
                bus.req_mul = '1;
                bus.req_ls  = '1;
            end
            rst = (k == 1 || k == 2);
            case (k)
                0: begin
                    x.g0 = 1'b1; x.a0 = 4'd0; x.g1 = 1'b1; x.a1 = 4'd1;
                    x.gm = 1'b1; x.am = 4'd0; x.gl = 1'b1; x.al = 4'd0;
                end
                1: begin x.busy = 1'b1; x.cred = 3'd3; end
                default: ;
            endcase
            sb.push_back(x);
            #3;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL rst_mul_cycle%0d: got %h required %h", k, obs(), e);
            end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_alu_select();
        test_mul_fsm();
        test_ls_credits();
        test_flush();
        test_rst_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
